// File: rtl/bsg_8b10b_pkg.sv
// Shared constants, valid control-code list, transmitter states and bit-order helpers
// for the 8b10b encoder.
package bsg_8b10b_pkg;

  localparam logic [9:0] K28_5_RDN = 10'h17C;
  localparam logic [9:0] K28_5_RDP = 10'h283;

  localparam int unsigned K_CODE_N = 12;
  localparam logic [7:0] K_CODES [K_CODE_N] = '{
    8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC,
    8'hF7, 8'hFB, 8'hFD, 8'hFE
  };

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    RUN    = 2'd1,
    INSERT = 2'd2
  } state_e;

  // Tables are written in transmission order (a first); the symbol bus puts a at bit 0.
  function automatic logic [5:0] rev6(input logic [5:0] v);
    logic [5:0] r;
    for (int unsigned i = 0; i < 6; i++) r[i] = v[5-i];
    return r;
  endfunction

  function automatic logic [3:0] rev4(input logic [3:0] v);
    logic [3:0] r;
    for (int unsigned i = 0; i < 4; i++) r[i] = v[3-i];
    return r;
  endfunction

endpackage

// File: rtl/bsg_8b10b_encode_comb.sv
// Combinational 8b10b encoder: one byte plus incoming running disparity to a 10b symbol.
module bsg_8b10b_encode_comb
  import bsg_8b10b_pkg::*;
(
  input  logic [7:0] data,
  input  logic       k,
  input  logic       rd_in,
  output logic [9:0] symbol,
  output logic       rd_out,
  output logic       kerr
);

  logic [4:0]  x;
  logic [2:0]  y;
  logic        k_valid;
  logic        k28;
  logic        alt7;
  logic        rd_mid;
  logic [12:0] t6;   // {flips_rd, rd- code, rd+ code}
  logic [8:0]  t4;   // {flips_rd, rd- code, rd+ code}
  logic [5:0]  code6;
  logic [3:0]  code4;

  assign x = data[4:0];
  assign y = data[7:5];

  always_comb begin
    k_valid = 1'b0;
    for (int unsigned i = 0; i < K_CODE_N; i++) begin
      if (k && (data == K_CODES[i])) k_valid = 1'b1;
    end
  end

  assign kerr = k & ~k_valid;
  assign k28  = k_valid & (x == 5'd28);

  // 5b/6b sub-block
  always_comb begin
    t6 = '0;
    if (k28) begin
      t6 = {1'b1, 6'b001111, 6'b110000};
    end else begin
      case (x)
        5'd0:  t6 = {1'b1, 6'b100111, 6'b011000};
        5'd1:  t6 = {1'b1, 6'b011101, 6'b100010};
        5'd2:  t6 = {1'b1, 6'b101101, 6'b010010};
        5'd3:  t6 = {1'b0, 6'b110001, 6'b110001};
        5'd4:  t6 = {1'b1, 6'b110101, 6'b001010};
        5'd5:  t6 = {1'b0, 6'b101001, 6'b101001};
        5'd6:  t6 = {1'b0, 6'b011001, 6'b011001};
        5'd7:  t6 = {1'b0, 6'b111000, 6'b000111};
        5'd8:  t6 = {1'b1, 6'b111001, 6'b000110};
        5'd9:  t6 = {1'b0, 6'b100101, 6'b100101};
        5'd10: t6 = {1'b0, 6'b010101, 6'b010101};
        5'd11: t6 = {1'b0, 6'b110100, 6'b110100};
        5'd12: t6 = {1'b0, 6'b001101, 6'b001101};
        5'd13: t6 = {1'b0, 6'b101100, 6'b101100};
        5'd14: t6 = {1'b0, 6'b011100, 6'b011100};
        5'd15: t6 = {1'b1, 6'b010111, 6'b101000};
        5'd16: t6 = {1'b1, 6'b011011, 6'b100100};
        5'd17: t6 = {1'b0, 6'b100011, 6'b100011};
        5'd18: t6 = {1'b0, 6'b010011, 6'b010011};
        5'd19: t6 = {1'b0, 6'b110010, 6'b110010};
        5'd20: t6 = {1'b0, 6'b001011, 6'b001011};
        5'd21: t6 = {1'b0, 6'b101010, 6'b101010};
        5'd22: t6 = {1'b0, 6'b011010, 6'b011010};
        5'd23: t6 = {1'b1, 6'b111010, 6'b000101};
        5'd24: t6 = {1'b1, 6'b110011, 6'b001100};
        5'd25: t6 = {1'b0, 6'b100110, 6'b100110};
        5'd26: t6 = {1'b0, 6'b010110, 6'b010110};
        5'd27: t6 = {1'b1, 6'b110110, 6'b001001};
        5'd28: t6 = {1'b0, 6'b001110, 6'b001110};
        5'd29: t6 = {1'b1, 6'b101110, 6'b010001};
        5'd30: t6 = {1'b1, 6'b011110, 6'b100001};
        5'd31: t6 = {1'b1, 6'b101011, 6'b010100};
      endcase
    end
  end

  assign code6  = rd_in ? t6[5:0] : t6[11:6];
  assign rd_mid = rd_in ^ t6[12];

  // D.x.A7 avoids a run of five equal bits across the sub-block boundary
  assign alt7 = (y == 3'd7) &
                ((~rd_mid & ((x == 5'd17) | (x == 5'd18) | (x == 5'd20))) |
                 ( rd_mid & ((x == 5'd11) | (x == 5'd13) | (x == 5'd14))));

  // 3b/4b sub-block
  always_comb begin
    t4 = '0;
    if (k28) begin
      case (y)
        3'd0: t4 = {1'b1, 4'b1011, 4'b0100};
        3'd1: t4 = {1'b0, 4'b0110, 4'b1001};
        3'd2: t4 = {1'b0, 4'b1010, 4'b0101};
        3'd3: t4 = {1'b0, 4'b1100, 4'b0011};
        3'd4: t4 = {1'b1, 4'b1101, 4'b0010};
        3'd5: t4 = {1'b0, 4'b0101, 4'b1010};
        3'd6: t4 = {1'b0, 4'b1001, 4'b0110};
        3'd7: t4 = {1'b1, 4'b0111, 4'b1000};
      endcase
    end else if (k_valid || alt7) begin
      t4 = {1'b1, 4'b0111, 4'b1000};
    end else begin
      case (y)
        3'd0: t4 = {1'b1, 4'b1011, 4'b0100};
        3'd1: t4 = {1'b0, 4'b1001, 4'b1001};
        3'd2: t4 = {1'b0, 4'b0101, 4'b0101};
        3'd3: t4 = {1'b0, 4'b1100, 4'b0011};
        3'd4: t4 = {1'b1, 4'b1101, 4'b0010};
        3'd5: t4 = {1'b0, 4'b1010, 4'b1010};
        3'd6: t4 = {1'b0, 4'b0110, 4'b0110};
        3'd7: t4 = {1'b1, 4'b1110, 4'b0001};
      endcase
    end
  end

  assign code4  = rd_mid ? t4[3:0] : t4[7:4];
  assign rd_out = rd_mid ^ t4[8];
  assign symbol = {rev4(code4), rev6(code6)};

endmodule

// File: rtl/bsg_8b10b_encode_tx.sv
// Handshaked 8b10b transmitter: single-slot output register, running disparity,
// K28.5 init burst, periodic comma insertion and optional idle fill.
module bsg_8b10b_encode_tx
  import bsg_8b10b_pkg::*;
#(
  parameter int unsigned init_commas_p  = 4,
  parameter int unsigned comma_period_p = 0,
  parameter int unsigned idle_comma_p   = 1
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       v_i,
  input  logic [7:0] data_i,
  input  logic       k_i,
  output logic       ready_o,
  output logic       v_o,
  output logic [9:0] data_o,
  input  logic       ready_i,
  output logic       rd_o,
  output logic       kerr_o
);

  localparam int unsigned ICNT_W = (init_commas_p < 2) ? 1 : $clog2(init_commas_p + 1);
  localparam int unsigned WCNT_W = (comma_period_p == 0) ? 1 : $clog2(comma_period_p + 1);

  state_e            state_r;
  logic [ICNT_W-1:0] icnt_r;
  logic [WCNT_W-1:0] wcnt_r;
  logic [WCNT_W-1:0] wcnt_inc;
  logic              insert_due_r;
  logic              slot_free;
  logic              insert_hit;
  logic [9:0]        comma;
  logic [9:0]        enc_symbol;
  logic              enc_rd;
  logic              enc_kerr;

  bsg_8b10b_encode_comb encoder (
    .data   (data_i),
    .k      (k_i),
    .rd_in  (rd_o),
    .symbol (enc_symbol),
    .rd_out (enc_rd),
    .kerr   (enc_kerr)
  );

  assign slot_free  = ~v_o | ready_i;
  assign ready_o    = (state_r == RUN) & slot_free & ~insert_due_r;
  assign comma      = rd_o ? K28_5_RDP : K28_5_RDN;
  assign wcnt_inc   = wcnt_r + WCNT_W'(1);
  assign insert_hit = (comma_period_p != 0) && (wcnt_inc == WCNT_W'(comma_period_p));

  // rd_o doubles as the running-disparity register; every K28.5 flips it
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r      <= INIT;
      icnt_r       <= '0;
      wcnt_r       <= '0;
      insert_due_r <= 1'b0;
      v_o          <= 1'b0;
      data_o       <= '0;
      rd_o         <= 1'b0;
      kerr_o       <= 1'b0;
    end else begin
      case (state_r)
        INIT: begin
          if (slot_free) begin
            v_o    <= 1'b1;
            data_o <= comma;
            rd_o   <= ~rd_o;
            kerr_o <= 1'b0;
            if (icnt_r == ICNT_W'(init_commas_p - 1)) begin
              state_r <= RUN;
              icnt_r  <= '0;
            end else begin
              icnt_r <= icnt_r + ICNT_W'(1);
            end
          end
        end
        RUN: begin
          if (ready_o && v_i) begin
            v_o    <= 1'b1;
            data_o <= enc_symbol;
            rd_o   <= enc_rd;
            kerr_o <= enc_kerr;
            if (insert_hit) begin
              wcnt_r       <= '0;
              insert_due_r <= 1'b1;
              state_r      <= INSERT;
            end else begin
              wcnt_r <= wcnt_inc;
            end
          end else if (slot_free && !insert_due_r) begin
            if (idle_comma_p != 0) begin
              v_o    <= 1'b1;
              data_o <= comma;
              rd_o   <= ~rd_o;
              kerr_o <= 1'b0;
            end else begin
              v_o <= 1'b0;
            end
          end
        end
        INSERT: begin
          if (slot_free) begin
            v_o          <= 1'b1;
            data_o       <= comma;
            rd_o         <= ~rd_o;
            kerr_o       <= 1'b0;
            insert_due_r <= 1'b0;
            state_r      <= RUN;
          end
        end
        default: state_r <= INIT;
      endcase
    end
  end

endmodule
